mio_bus: RTL and testbench

- Memory/IO bus controller directly downstream of the pipelined CPU core's data port.
- Decodes the CPU's word address and sequences each access to one of three targets: the data RAM, the LED/switch/7-seg registers, or a programmable down-counter.
- Runs a ready handshake back to the CPU. Raises the counter interrupt that feeds the core's INT input.

---
 rtl/mio_bus_pkg.sv | 51 +++++
 rtl/mio_counter.sv | 87 ++++++++
 rtl/mio_bus.sv | 143 ++++++++++++++
 tb/tb_mio_bus.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_bus_pkg.sv
`default_nettype none
// ============================================================================
// mio_bus_pkg : address map, control-bit indices, FSM encoding and decoder
//               shared by the memory/IO bus controller and its counter.
// Revision    : 1.0
// ============================================================================
package mio_bus_pkg;

    localparam logic [31:0] RAM_BASE      = 32'h0000_0000;
    localparam logic [31:0] RAM_LIMIT     = 32'h0000_0FFF;
    localparam logic [31:0] SEG_ADDR      = 32'hE000_0000;
    localparam logic [31:0] LED_ADDR      = 32'hF000_0000;
    localparam logic [31:0] CNT_VAL_ADDR  = 32'hF000_0004;
    localparam logic [31:0] CNT_CTRL_ADDR = 32'hF000_0008;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;
    localparam int CTRL_IRQ  = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [2:0] {
        TGT_NONE,
        TGT_RAM,
        TGT_SEG,
        TGT_LED,
        TGT_CVAL,
        TGT_CCTRL
    } tgt_e;

    // Decoding works on word addresses; the byte offset never matters.
    function automatic tgt_e decode_tgt(input logic [29:0] waddr);
        tgt_e t;
        t = TGT_NONE;
        if ((waddr - RAM_BASE[31:2]) <= (RAM_LIMIT[31:2] - RAM_BASE[31:2]))
            t = TGT_RAM;
        else if (waddr == SEG_ADDR[31:2])
            t = TGT_SEG;
        else if (waddr == LED_ADDR[31:2])
            t = TGT_LED;
        else if (waddr == CNT_VAL_ADDR[31:2])
            t = TGT_CVAL;
        else if (waddr == CNT_CTRL_ADDR[31:2])
            t = TGT_CCTRL;
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mio_counter.sv
`default_nettype none
// ============================================================================
// mio_counter : programmable down-counter with reload, one-shot/auto modes
//               and a write-1-to-clear expiry flag.
// Revision    : 1.0
// ============================================================================
module mio_counter
    import mio_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        val_we_i,
    input  logic        ctrl_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] val_o,
    output logic [31:0] ctrl_o,
    output logic        irq_o
);

    logic [31:0] val_q, val_d;
    logic [31:0] reload_q, reload_d;
    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        irq_q, irq_d;
    logic        w_step;
    logic        w_expire;

    always_comb begin
        w_step   = en_q && (val_q != 32'd0);
        // A CPU load in the same cycle pre-empts the 1->0 transition.
        w_expire = w_step && (val_q == 32'd1) && !val_we_i;

        val_d    = val_q;
        reload_d = reload_q;
        en_d     = en_q;
        auto_d   = auto_q;
        irq_d    = irq_q;

        if (val_we_i) begin
            val_d    = wdata_i;
            reload_d = wdata_i;
        end else if (w_step) begin
            val_d = (w_expire && auto_q) ? reload_q : (val_q - 32'd1);
        end

        if (ctrl_we_i) begin
            en_d   = wdata_i[CTRL_EN];
            auto_d = wdata_i[CTRL_AUTO];
            if (wdata_i[CTRL_IRQ])
                irq_d = 1'b0;
        end

        if (w_expire) begin
            irq_d = 1'b1;
            if (!auto_q && !ctrl_we_i)
                en_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q    <= 32'd0;
            reload_q <= 32'd0;
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            val_q    <= val_d;
            reload_q <= reload_d;
            en_q     <= en_d;
            auto_q   <= auto_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        ctrl_o            = 32'd0;
        ctrl_o[CTRL_EN]   = en_q;
        ctrl_o[CTRL_AUTO] = auto_q;
        ctrl_o[CTRL_IRQ]  = irq_q;
    end

    assign val_o = val_q;
    assign irq_o = irq_q;

endmodule
`default_nettype wire

// File: rtl/mio_bus.sv
`default_nettype none
// ============================================================================
// mio_bus : CPU data-port bus controller; decodes RAM / LED-switch / 7-seg /
//           counter targets and runs the ready handshake back to the core.
// Revision: 1.0
// ============================================================================
module mio_bus
    import mio_bus_pkg::*;
#(
    parameter int RAM_AW  = 10,
    parameter int RAM_LAT = 1,
    parameter int LED_W   = 16,
    parameter int SW_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              mio_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [SW_W-1:0]   sw_in,
    output logic [LED_W-1:0]  led_out,
    output logic [31:0]       seg_data,
    output logic              counter_irq
);

    localparam logic [2:0] LAT_LAST = 3'(RAM_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [RAM_AW-1:0] addr_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic              is_ram_q;
    logic [2:0]        lat_q;
    logic [31:0]       rdata_q;
    logic [LED_W-1:0]  led_q;
    logic [31:0]       seg_q;

    tgt_e              w_tgt;
    logic              w_accept;
    logic              w_val_we;
    logic              w_ctrl_we;
    logic [31:0]       w_cnt_val;
    logic [31:0]       w_cnt_ctrl;
    logic [31:0]       w_rd_mux;
    logic              unused_addr_bits;

    assign w_tgt            = decode_tgt(cpu_addr[31:2]);
    assign w_accept         = (state_q == ST_IDLE) && cpu_req;
    assign w_val_we         = w_accept && cpu_we && (w_tgt == TGT_CVAL);
    assign w_ctrl_we        = w_accept && cpu_we && (w_tgt == TGT_CCTRL);
    assign unused_addr_bits = ^cpu_addr[1:0];

    mio_counter u_counter (
        .clk       (clk),
        .rst       (rst),
        .val_we_i  (w_val_we),
        .ctrl_we_i (w_ctrl_we),
        .wdata_i   (cpu_wdata),
        .val_o     (w_cnt_val),
        .ctrl_o    (w_cnt_ctrl),
        .irq_o     (counter_irq)
    );

    always_comb begin
        w_rd_mux = 32'd0;
        case (w_tgt)
            TGT_SEG:   w_rd_mux = seg_q;
            TGT_LED:   w_rd_mux = 32'(sw_in);
            TGT_CVAL:  w_rd_mux = w_cnt_val;
            TGT_CCTRL: w_rd_mux = w_cnt_ctrl;
            default:   w_rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req)
                    state_d = (!cpu_we && (w_tgt == TGT_RAM)) ? ST_WAIT : ST_DONE;
            end
            ST_WAIT: begin
                if (lat_q == LAT_LAST)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= 32'd0;
            is_ram_q <= 1'b0;
            lat_q    <= 3'd0;
            rdata_q  <= 32'd0;
            led_q    <= '0;
            seg_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            if (w_accept) begin
                addr_q   <= cpu_addr[RAM_AW+1:2];
                we_q     <= cpu_we;
                wdata_q  <= cpu_wdata;
                is_ram_q <= (w_tgt == TGT_RAM);
                lat_q    <= 3'd0;
                if (!cpu_we && (w_tgt != TGT_RAM))
                    rdata_q <= w_rd_mux;
                if (cpu_we && (w_tgt == TGT_SEG))
                    seg_q <= cpu_wdata;
                if (cpu_we && (w_tgt == TGT_LED))
                    led_q <= cpu_wdata[LED_W-1:0];
            end
            if (state_q == ST_WAIT) begin
                lat_q <= lat_q + 3'd1;
                if (lat_q == LAT_LAST)
                    rdata_q <= ram_rdata;
            end
        end
    end

    // The RAM samples the live address on the accept edge so read data is
    // ready RAM_LAT cycles later; afterwards the latched address is held.
    assign ram_addr  = (state_q == ST_IDLE) ? cpu_addr[RAM_AW+1:2] : addr_q;
    assign ram_we    = (state_q == ST_DONE) && we_q && is_ram_q;
    assign ram_wdata = wdata_q;
    assign cpu_rdata = rdata_q;
    assign mio_ready = (state_q == ST_DONE);
    assign led_out   = led_q;
    assign seg_data  = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_mio_bus.sv
`default_nettype none
// ============================================================================
// tb_mio_bus : randomized and directed bench for mio_bus with RAM model and
//              a reference scoreboard of RAM, LED, 7-seg and counter timing.
// Revision   : 1.0
// ============================================================================
module tb_mio_bus;

    localparam int RAM_AW  = 10;
    localparam int RAM_LAT = 1;
    localparam int LED_W   = 16;
    localparam int SW_W    = 16;

    localparam logic [31:0] A_SEG  = 32'hE000_0000;
    localparam logic [31:0] A_LED  = 32'hF000_0000;
    localparam logic [31:0] A_CVAL = 32'hF000_0004;
    localparam logic [31:0] A_CTRL = 32'hF000_0008;

    logic              clk;
    logic              rst;
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              mio_ready;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [SW_W-1:0]   sw_in;
    logic [LED_W-1:0]  led_out;
    logic [31:0]       seg_data;
    logic              counter_irq;

    mio_bus #(
        .RAM_AW (RAM_AW),
        .RAM_LAT(RAM_LAT),
        .LED_W  (LED_W),
        .SW_W   (SW_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .mio_ready  (mio_ready),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .sw_in      (sw_in),
        .led_out    (led_out),
        .seg_data   (seg_data),
        .counter_irq(counter_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with RAM_LAT cycles of read latency.
    logic [31:0]       ram_mem [0:(1<<RAM_AW)-1];
    logic [31:0]       rd_pipe [0:RAM_LAT-1];
    logic              mem_clr;
    int                we_pulses = 0;
    logic [RAM_AW-1:0] we_addr;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << RAM_AW); i++) ram_mem[i] <= 32'd0;
        end else if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
            we_pulses         <= we_pulses + 1;
            we_addr           <= ram_addr;
        end
        rd_pipe[0] <= ram_mem[ram_addr];
        for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RAM_LAT-1];

    logic [31:0]      ref_mem [0:(1<<RAM_AW)-1];
    logic [31:0]      ref_seg;
    logic [LED_W-1:0] ref_led;
    int checks = 0;
    int errors = 0;

    // Called #1 after an edge with the bus idle; returns #1 after the edge
    // that takes the controller back to idle.
    task automatic do_access(input logic we, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] rd,
                             output int lat, output int acc);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        lat = 0;
        acc = 0;
        rd  = 32'd0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 1) acc = cyc;
            if (mio_ready) begin
                lat = c;
                rd  = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        if (lat == 0) begin
            checks++; errors++;
            $display("FAIL ready_timeout addr=%h: no mio_ready within 20 cycles", addr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd; int lat, acc;
        rst = 1'b1; mem_clr = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; sw_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cpu_rdata, mio_ready, ram_we, led_out, seg_data, counter_irq} !== 83'd0) begin
            errors++;
            $display("FAIL reset_outputs: rdata=%h ready=%b we=%b led=%h seg=%h irq=%b want all 0",
                     cpu_rdata, mio_ready, ram_we, led_out, seg_data, counter_irq);
        end
        rst = 1'b0; mem_clr = 1'b0;
        @(posedge clk); #1;
        do_access(1'b0, A_CTRL, 32'd0, rd, lat, acc);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", rd); end
        do_access(1'b0, A_CVAL, 32'd0, rd, lat, acc);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_cval: got %h want 0", rd); end
    endtask

    task automatic test_ram();
        logic [31:0] rd; int lat, acc, p0;
        p0 = we_pulses;
        do_access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, lat, acc);
        ref_mem[4] = 32'hDEAD_BEEF;
        checks++;
        if (we_pulses !== p0 + 1 || we_addr !== 10'd4) begin
            errors++;
            $display("FAIL ram_we_pulse: pulses=%0d addr=%0d want 1 addr 4", we_pulses - p0, we_addr);
        end
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL ram_write_lat: got %0d want 1", lat); end
        do_access(1'b0, 32'h0000_0010, 32'd0, rd, lat, acc);
        checks++;
        if (lat !== 1 + RAM_LAT) begin errors++; $display("FAIL ram_read_lat: got %0d want %0d", lat, 1 + RAM_LAT); end
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_read_data: got %h want deadbeef", rd); end
    endtask

    task automatic test_led_sw();
        logic [31:0] rd; int lat, acc;
        sw_in = 16'h1234;
        do_access(1'b1, A_LED, 32'h0000_A5A5, rd, lat, acc);
        ref_led = 16'hA5A5;
        checks++;
        if (led_out !== 16'hA5A5 || lat !== 1) begin
            errors++; $display("FAIL led_write: led=%h lat=%0d want a5a5 lat 1", led_out, lat);
        end
        do_access(1'b0, A_LED, 32'd0, rd, lat, acc);
        checks++;
        if (rd !== 32'h0000_1234) begin errors++; $display("FAIL sw_read: got %h want 00001234", rd); end
        do_access(1'b1, A_SEG, 32'hCAFE_F00D, rd, lat, acc);
        ref_seg = 32'hCAFE_F00D;
        checks++;
        if (seg_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL seg_write: got %h want cafef00d", seg_data); end
        checks++;
        if (cpu_rdata !== 32'h0000_1234) begin errors++; $display("FAIL rdata_hold: got %h want 00001234", cpu_rdata); end
        do_access(1'b0, A_SEG, 32'd0, rd, lat, acc);
        checks++;
        if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL seg_read: got %h want cafef00d", rd); end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd; int lat, acc;
        do_access(1'b0, 32'h8000_0000, 32'd0, rd, lat, acc);
        checks++;
        if (rd !== 32'd0 || lat !== 1) begin
            errors++; $display("FAIL unmapped_read: data=%h lat=%0d want 0 lat 1", rd, lat);
        end
        do_access(1'b1, 32'h8000_0004, 32'h1111_2222, rd, lat, acc);
        checks++;
        if (seg_data !== ref_seg || led_out !== ref_led || lat !== 1) begin
            errors++; $display("FAIL unmapped_write: seg=%h led=%h lat=%0d want %h %h 1", seg_data, led_out, lat, ref_seg, ref_led);
        end
    endtask

    task automatic test_counter_auto();
        logic [31:0] rd, ex; int lat, acc, b, e;
        do_access(1'b1, A_CVAL, 32'd5, rd, lat, acc);
        do_access(1'b1, A_CTRL, 32'h3, rd, lat, b);
        // Value after edge b+j is 5 - (j mod 5); expiry edges are b+5k.
        for (int n = b + 1; n <= b + 5; n++) begin
            if (n != b + 1) begin @(posedge clk); #1; end
            checks++;
            if (counter_irq !== (n == b + 5)) begin
                errors++; $display("FAIL auto_irq edge+%0d: got %b want %b", n - b, counter_irq, n == b + 5);
            end
        end
        for (int k = 0; k < 5; k++) begin
            do_access(1'b0, A_CVAL, 32'd0, rd, lat, acc);
            ex = 32'(5 - ((acc - 1 - b) % 5));
            checks++;
            if (rd !== ex) begin errors++; $display("FAIL auto_value read%0d: got %0d want %0d", k, rd, ex); end
        end
        do_access(1'b1, A_CTRL, 32'h7, rd, lat, e);
        checks++;
        if (counter_irq !== (((e - b) % 5 == 0) || ((e + 1 - b) % 5 == 0))) begin
            errors++; $display("FAIL auto_w1c: irq=%b after clear at edge+%0d", counter_irq, e - b);
        end
        do_access(1'b0, A_CTRL, 32'd0, rd, lat, acc);
        checks++;
        if (rd[1:0] !== 2'b11) begin errors++; $display("FAIL auto_ctrl_keep: got %b want 11", rd[1:0]); end
    endtask

    task automatic test_counter_oneshot();
        logic [31:0] rd; int lat, acc, b;
        do_access(1'b1, A_CTRL, 32'h0, rd, lat, acc);
        do_access(1'b1, A_CTRL, 32'h4, rd, lat, acc);
        checks++;
        if (counter_irq !== 1'b0) begin errors++; $display("FAIL oneshot_clear: got %b want 0", counter_irq); end
        do_access(1'b1, A_CVAL, 32'd2, rd, lat, acc);
        do_access(1'b1, A_CTRL, 32'h1, rd, lat, b);
        checks++;
        if (counter_irq !== 1'b0) begin errors++; $display("FAIL oneshot_early: got %b want 0", counter_irq); end
        @(posedge clk); #1;
        checks++;
        if (counter_irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq: got %b want 1", counter_irq); end
        repeat (3) @(posedge clk);
        #1;
        do_access(1'b0, A_CVAL, 32'd0, rd, lat, acc);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL oneshot_hold0: got %0d want 0", rd); end
        do_access(1'b0, A_CTRL, 32'd0, rd, lat, acc);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL oneshot_ctrl: got %h want 4", rd); end
    endtask

    task automatic test_irq_race();
        logic [31:0] rd; int lat, acc, b;
        do_access(1'b1, A_CTRL, 32'h4, rd, lat, acc);
        do_access(1'b1, A_CVAL, 32'd3, rd, lat, acc);
        do_access(1'b1, A_CTRL, 32'h1, rd, lat, b);
        @(posedge clk); #1;
        do_access(1'b1, A_CTRL, 32'h4, rd, lat, acc);
        checks++;
        if (acc !== b + 3) begin errors++; $display("FAIL race_timing: clear at edge+%0d want edge+3", acc - b); end
        checks++;
        if (counter_irq !== 1'b1) begin errors++; $display("FAIL race_set_wins: got %b want 1", counter_irq); end
        do_access(1'b0, A_CTRL, 32'd0, rd, lat, acc);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL race_ctrl: got %h want 4", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, a, ex; logic [9:0] wa; int lat, acc, op, exlat;
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 5);
            wd = $urandom;
            wa = 10'($urandom_range(0, 31));
            a  = {20'h0, wa, 2'($urandom)};
            exlat = 1;
            case (op)
                0: begin do_access(1'b1, a, wd, rd, lat, acc); ref_mem[wa] = wd; ex = ref_mem[wa]; rd = ram_mem[wa]; end
                1: begin do_access(1'b0, a, 32'd0, rd, lat, acc); ex = ref_mem[wa]; exlat = 1 + RAM_LAT; end
                2: begin do_access(1'b1, A_SEG, wd, rd, lat, acc); ref_seg = wd; ex = ref_seg; rd = seg_data; end
                3: begin do_access(1'b0, A_SEG | 32'(wa[1:0]), 32'd0, rd, lat, acc); ex = ref_seg; end
                4: begin do_access(1'b1, A_LED, wd, rd, lat, acc); ref_led = wd[15:0]; ex = 32'(ref_led); rd = 32'(led_out); end
                default: begin
                    sw_in = 16'($urandom);
                    do_access(1'b0, A_LED | 32'(wa[1:0]), 32'd0, rd, lat, acc);
                    ex = {16'h0, sw_in};
                end
            endcase
            checks++;
            if (rd !== ex || lat !== exlat) begin
                errors++;
                $display("FAIL random op%0d #%0d: data=%h lat=%0d want %h lat %0d", op, i, rd, lat, ex, exlat);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd; int lat, acc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
        @(posedge clk); #1;
        rst = 1'b1; cpu_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({cpu_rdata, mio_ready, ram_we, led_out, seg_data, counter_irq} !== 83'd0) begin
                errors++;
                $display("FAIL wait_reset cyc%0d: rdata=%h ready=%b we=%b led=%h seg=%h irq=%b want all 0",
                         k, cpu_rdata, mio_ready, ram_we, led_out, seg_data, counter_irq);
            end
        end
        rst = 1'b0;
        ref_seg = 32'd0; ref_led = '0;
        @(posedge clk); #1;
        checks++;
        if (mio_ready !== 1'b0) begin errors++; $display("FAIL wait_reset_ready: got %b want 0", mio_ready); end
        do_access(1'b0, A_CTRL, 32'd0, rd, lat, acc);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL wait_reset_ctrl: got %h want 0", rd); end
        do_access(1'b0, 32'h0000_0010, 32'd0, rd, lat, acc);
        checks++;
        if (rd !== ref_mem[4] || lat !== 1 + RAM_LAT) begin
            errors++; $display("FAIL post_reset_read: data=%h lat=%0d want %h lat %0d", rd, lat, ref_mem[4], 1 + RAM_LAT);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << RAM_AW); i++) ref_mem[i] = 32'd0;
        ref_seg = 32'd0;
        ref_led = '0;
        test_reset();
        test_ram();
        test_led_sw();
        test_unmapped();
        test_counter_auto();
        test_counter_oneshot();
        test_irq_race();
        test_random();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
